// File: rtl/conv_row_sequencer_pkg.sv
// Package shared by the convolution row sequencer and its counter.
// Holds the sequencer state encoding, the counter width helper and the
// width of the optional stall counter (CONV_SEQ_PERF_EN builds only).
package conv_seq_pkg;

  localparam int SEQ_PERF_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_ROW_GAP = 2'd2,
    ST_PAD_ROW = 2'd3
  } conv_seq_state_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int seq_cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_row_sequencer_wrap_counter.sv
// wrap_counter: modulo-MODULUS counter with enable, synchronous clear and
// terminal-count flag.
// Ports:
//   clk, rstn  clock, asynchronous active-low reset
//   i_en       advance by one (wraps to 0 after MODULUS-1)
//   i_clr      synchronous clear, takes priority over i_en
//   o_cnt      current count
//   o_tc       count is at MODULUS-1
module wrap_counter
  import conv_seq_pkg::*;
#(
  parameter int MODULUS = 4,
  parameter int W       = seq_cnt_w(MODULUS)
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MODULUS - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/conv_row_sequencer.sv
// conv_row_sequencer: frame sequencer for the convolution input path.
// Turns a raster pixel stream into line_buffer_controller strobes, inserts a
// KER_SIZE-cycle drain gap after every row, synthesises PAD bottom zero rows
// and qualifies each column with window-valid and top/bottom padding masks.
// Optional feature macro: CONV_SEQ_PERF_EN adds the 32-bit stall_cycles port.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   start              frame start pulse (IDLE only)
//   in_valid/in_ready  upstream pixel handshake
//   out_ready          downstream can take a column this cycle
//   lb_valid           column strobe to the line buffer
//   lb_row_complete    one-cycle pulse in the first gap cycle of each row
//   pad_fill           current column is a synthesised zero
//   window_valid       column completes a legal output row window
//   top_pad_mask       kernel rows above row 0 (bit 0 = oldest row)
//   bottom_pad_mask    kernel rows below the last input row
//   row_idx            current sequencer row
//   busy               not IDLE
//   stall_cycles       STREAM cycles without an accept (CONV_SEQ_PERF_EN)
//   frame_done         one-cycle pulse in the first IDLE cycle after a frame
module conv_row_sequencer
  import conv_seq_pkg::*;
#(
  parameter int KER_SIZE    = 3,
  parameter int INPUT_X_DIM = 3,
  parameter int INPUT_Y_DIM = 3,
  parameter int PAD         = 1
) (
  input  logic                                      clk,
  input  logic                                      rstn,
  input  logic                                      start,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic                                      out_ready,
  output logic                                      lb_valid,
  output logic                                      lb_row_complete,
  output logic                                      pad_fill,
  output logic                                      window_valid,
  output logic [KER_SIZE-1:0]                       top_pad_mask,
  output logic [KER_SIZE-1:0]                       bottom_pad_mask,
  output logic [seq_cnt_w(INPUT_Y_DIM+PAD+1)-1:0]   row_idx,
  output logic                                      busy,
`ifdef CONV_SEQ_PERF_EN
  output logic [SEQ_PERF_W-1:0]                     stall_cycles,
`endif
  output logic                                      frame_done
);

  localparam int RW        = seq_cnt_w(INPUT_Y_DIM + PAD + 1);
  localparam int CW        = seq_cnt_w(INPUT_X_DIM);
  localparam int GW        = seq_cnt_w(KER_SIZE);
  localparam int WIN_FIRST = KER_SIZE - 1 - PAD;
  localparam int LAST_ROW  = INPUT_Y_DIM + PAD - 1;
  localparam logic signed [RW:0] ZERO_S = '0;
  localparam logic signed [RW:0] YDIM_S = (RW+1)'(INPUT_Y_DIM);

  if (KER_SIZE - 1 < PAD) begin : g_bad_pad
    $error("conv_row_sequencer: PAD must not exceed KER_SIZE-1");
  end
  if (INPUT_X_DIM < 1 || INPUT_Y_DIM < 1) begin : g_bad_dim
    $error("conv_row_sequencer: INPUT_X_DIM and INPUT_Y_DIM must be >= 1");
  end

  conv_seq_state_e r_state;
  logic [RW-1:0]   r_row;
  logic            r_frame_done;

  logic            w_start_acc;
  logic            w_accept;
  logic            w_col_en;
  logic            w_col_tc;
  logic            w_row_end;
  logic            w_gap_en;
  logic            w_gap_tc;
  logic [GW-1:0]   w_gap_cnt;
  // Only the column counter's terminal flag steers the FSM; the position
  // itself has no consumer.
  logic [CW-1:0]   w_col_cnt_unused;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_accept    = (r_state == ST_STREAM) && in_valid && out_ready;
  assign w_col_en    = w_accept || ((r_state == ST_PAD_ROW) && out_ready);
  assign w_row_end   = w_col_en && w_col_tc;
  assign w_gap_en    = (r_state == ST_ROW_GAP);

  // Both counters wrap to zero on their own at row/gap end, so the only
  // explicit clear needed is at frame start.
  wrap_counter #(.MODULUS(INPUT_X_DIM), .W(CW)) u_col_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_en  (w_col_en),
    .i_clr (w_start_acc),
    .o_cnt (w_col_cnt_unused),
    .o_tc  (w_col_tc)
  );

  wrap_counter #(.MODULUS(KER_SIZE), .W(GW)) u_gap_cnt (
    .clk   (clk),
    .rstn  (rstn),
    .i_en  (w_gap_en),
    .i_clr (w_start_acc),
    .o_cnt (w_gap_cnt),
    .o_tc  (w_gap_tc)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_STREAM;
            r_row   <= '0;
          end
        end
        ST_STREAM, ST_PAD_ROW: begin
          if (w_row_end) r_state <= ST_ROW_GAP;
        end
        ST_ROW_GAP: begin
          if (w_gap_tc) begin
            r_row <= r_row + 1'b1;
            if (r_row == RW'(LAST_ROW)) begin
              r_state      <= ST_IDLE;
              r_frame_done <= 1'b1;
            end else if (int'(r_row) + 1 >= INPUT_Y_DIM) begin
              r_state <= ST_PAD_ROW;
            end else begin
              r_state <= ST_STREAM;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready        = (r_state == ST_STREAM) && out_ready;
  assign pad_fill        = (r_state == ST_PAD_ROW) && out_ready;
  assign lb_valid        = w_accept || pad_fill;
  assign lb_row_complete = w_gap_en && (w_gap_cnt == '0);
  assign busy            = (r_state != ST_IDLE);
  assign frame_done      = r_frame_done;
  assign row_idx         = r_row;
  assign window_valid    = lb_valid && (int'(r_row) >= WIN_FIRST);

  // Input row covered by kernel row k, relative to row 0:
  // row_idx - (KER_SIZE-1) + k, i.e. o - PAD + k.
  function automatic logic signed [RW:0] krow_rel(input logic [RW-1:0] row,
                                                  input int k);
    return $signed({1'b0, row}) - $signed((RW+1)'(KER_SIZE - 1))
           + $signed((RW+1)'(k));
  endfunction

  always_comb begin
    top_pad_mask    = '0;
    bottom_pad_mask = '0;
    for (int k = 0; k < KER_SIZE; k++) begin
      top_pad_mask[k]    = window_valid && (krow_rel(r_row, k) < ZERO_S);
      bottom_pad_mask[k] = window_valid && (krow_rel(r_row, k) >= YDIM_S);
    end
  end

`ifdef CONV_SEQ_PERF_EN
  logic [SEQ_PERF_W-1:0] r_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall <= '0;
    end else if (w_start_acc) begin
      r_stall <= '0;
    end else if ((r_state == ST_STREAM) && !w_accept && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_conv_row_sequencer.sv
module tb_conv_row_sequencer;

  localparam int K = 3;
  localparam int X = 4;

  logic clk, rstn, start, in_valid, out_ready;

  logic       a_inr, a_lbv, a_rc, a_pf, a_wv, a_busy, a_fd;
  logic [2:0] a_tpm, a_bpm, a_row;
  logic       b_inr, b_lbv, b_rc, b_pf, b_wv, b_busy, b_fd;
  logic [2:0] b_tpm, b_bpm;
  logic [1:0] b_row;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0] a_stall, b_stall;
`endif

  conv_row_sequencer #(.KER_SIZE(K), .INPUT_X_DIM(X), .INPUT_Y_DIM(4), .PAD(1)) u_a (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(a_inr),
    .out_ready(out_ready), .lb_valid(a_lbv), .lb_row_complete(a_rc), .pad_fill(a_pf),
    .window_valid(a_wv), .top_pad_mask(a_tpm), .bottom_pad_mask(a_bpm),
    .row_idx(a_row), .busy(a_busy),
`ifdef CONV_SEQ_PERF_EN
    .stall_cycles(a_stall),
`endif
    .frame_done(a_fd));

  conv_row_sequencer #(.KER_SIZE(K), .INPUT_X_DIM(X), .INPUT_Y_DIM(3), .PAD(0)) u_b (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(b_inr),
    .out_ready(out_ready), .lb_valid(b_lbv), .lb_row_complete(b_rc), .pad_fill(b_pf),
    .window_valid(b_wv), .top_pad_mask(b_tpm), .bottom_pad_mask(b_bpm),
    .row_idx(b_row), .busy(b_busy),
`ifdef CONV_SEQ_PERF_EN
    .stall_cycles(b_stall),
`endif
    .frame_done(b_fd));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_a_inr"}, a_inr, 0);   chk({tag, "_a_lbv"}, a_lbv, 0);
    chk({tag, "_a_rc"}, a_rc, 0);     chk({tag, "_a_pf"}, a_pf, 0);
    chk({tag, "_a_wv"}, a_wv, 0);     chk({tag, "_a_tpm"}, a_tpm, 0);
    chk({tag, "_a_bpm"}, a_bpm, 0);   chk({tag, "_a_row"}, a_row, 0);
    chk({tag, "_a_busy"}, a_busy, 0); chk({tag, "_a_fd"}, a_fd, 0);
    chk({tag, "_b_busy"}, b_busy, 0); chk({tag, "_b_lbv"}, b_lbv, 0);
`ifdef CONV_SEQ_PERF_EN
    chk({tag, "_a_stall"}, a_stall, 0);
`endif
  endtask

  // Free-flowing frame model: start at t=0, each row occupies X strobe
  // cycles followed by K gap cycles, Y+P rows, frame_done one cycle later.
  task automatic check_nostall(input string who, input int t, input int Y, input int P,
                               input logic lbv, input logic rc, input logic fd,
                               input logic pf, input logic wv, input logic [2:0] tpm,
                               input logic [2:0] bpm, input logic bsy, input logic inr,
                               input int ridx);
    int per, ph, row, pos, rel;
    bit active, e_lbv, e_wv;
    logic [2:0] e_t, e_b;
    string s;
    per    = X + K;
    ph     = t - 1;
    active = (t >= 1) && (ph < (Y + P) * per);
    row    = active ? ph / per : 0;
    pos    = active ? ph % per : 0;
    e_lbv  = active && (pos < X);
    e_wv   = e_lbv && (row >= K - 1 - P);
    for (int k = 0; k < 3; k++) begin
      rel    = row - (K - 1) + k;
      e_t[k] = e_wv && (rel < 0);
      e_b[k] = e_wv && (rel >= Y);
    end
    s = $sformatf("%s_t%0d", who, t);
    chk({s, "_lbv"}, lbv, e_lbv);
    chk({s, "_rc"}, rc, active && (pos == X));
    chk({s, "_fd"}, fd, t == 1 + (Y + P) * per);
    chk({s, "_pf"}, pf, e_lbv && (row >= Y));
    chk({s, "_inr"}, inr, e_lbv && (row < Y));
    chk({s, "_busy"}, bsy, active);
    chk({s, "_wv"}, wv, e_wv);
    chk({s, "_tpm"}, tpm, e_t);
    chk({s, "_bpm"}, bpm, e_b);
    if (active) chk({s, "_row"}, ridx, row);
  endtask

  task automatic run_nostall();
    start = 1; in_valid = 1; out_ready = 1;
    for (int t = 0; t <= 38; t++) begin
      @(negedge clk);
      check_nostall("A", t, 4, 1, a_lbv, a_rc, a_fd, a_pf, a_wv, a_tpm, a_bpm,
                    a_busy, a_inr, int'(a_row));
      check_nostall("B", t, 3, 0, b_lbv, b_rc, b_fd, b_pf, b_wv, b_tpm, b_bpm,
                    b_busy, b_inr, int'(b_row));
      @(posedge clk); #1;
      start = (t + 1 == 10);  // pulse while both instances are busy
    end
    start = 0;
`ifdef CONV_SEQ_PERF_EN
    chk("ns_a_stall", a_stall, 0);
    chk("ns_b_stall", b_stall, 0);
`endif
  endtask

  int rows_done, strobes, gap_rem, stall_left, budget, rel;
  bit force_one, stalled, fin, pad, e_lbv, e_wv;
  logic [2:0] e_t, e_b;
  longint exp_stall;

  initial begin
    rstn = 0; start = 0; in_valid = 1; out_ready = 1;
    #3;
    chk_reset("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk); rstn = 1;
    @(posedge clk); #1;

    // Free-flowing frame on both configurations.
    run_nostall();

    // Randomised handshake frame on instance A with a 3-cycle out_ready hold.
    start = 1; in_valid = 1'($urandom % 2); out_ready = 1'($urandom % 2);
    @(negedge clk);
    chk("t2_idle_lbv", a_lbv, 0);
    chk("t2_idle_inr", a_inr, 0);
    @(posedge clk); #1;
    start = 0;
    rows_done = 0; strobes = 0; gap_rem = 0; stall_left = 0;
    force_one = 0; stalled = 0; fin = 0; exp_stall = 0;
    for (budget = 0; budget < 400 && !fin; budget++) begin
      pad = (rows_done >= 4);
      if (gap_rem > 0 || force_one) begin
        in_valid = 1; out_ready = 1;
      end else if (stall_left > 0) begin
        out_ready = 0; in_valid = 1'(stall_left % 2); stall_left--;
      end else begin
        in_valid = 1'($urandom % 2); out_ready = (($urandom % 4) != 0);
      end
      start = (rows_done == 2 && strobes == 1);
      @(negedge clk);
      if (rows_done == 5) begin
        chk("t2_fd", a_fd, 1);
        chk("t2_fd_busy", a_busy, 0);
        chk("t2_fd_lbv", a_lbv, 0);
        fin = 1;
      end else if (gap_rem > 0) begin
        chk($sformatf("t2_gap_lbv_r%0d", rows_done), a_lbv, 0);
        chk($sformatf("t2_gap_inr_r%0d", rows_done), a_inr, 0);
        chk($sformatf("t2_gap_rc_r%0d", rows_done), a_rc, gap_rem == K);
        chk("t2_gap_fd", a_fd, 0);
        chk("t2_gap_busy", a_busy, 1);
        gap_rem--;
        if (gap_rem == 0) begin
          rows_done++; strobes = 0; force_one = 1;
        end
      end else begin
        e_lbv = pad ? out_ready : (in_valid && out_ready);
        e_wv  = e_lbv && (rows_done >= 1);
        for (int k = 0; k < 3; k++) begin
          rel    = rows_done - 2 + k;
          e_t[k] = e_wv && (rel < 0);
          e_b[k] = e_wv && (rel >= 4);
        end
        chk($sformatf("t2_lbv_r%0d", rows_done), a_lbv, e_lbv);
        chk($sformatf("t2_inr_r%0d", rows_done), a_inr, pad ? 1'b0 : out_ready);
        chk($sformatf("t2_pf_r%0d", rows_done), a_pf, pad && e_lbv);
        chk($sformatf("t2_rc_r%0d", rows_done), a_rc, 0);
        chk("t2_fd0", a_fd, 0);
        chk("t2_busy", a_busy, 1);
        chk($sformatf("t2_wv_r%0d", rows_done), a_wv, e_wv);
        chk($sformatf("t2_tpm_r%0d", rows_done), a_tpm, e_t);
        chk($sformatf("t2_bpm_r%0d", rows_done), a_bpm, e_b);
        if (force_one) chk($sformatf("t2_gap_len_r%0d", rows_done), a_lbv, 1);
        force_one = 0;
        if (!pad && !(in_valid && out_ready)) exp_stall++;
        if (e_lbv) begin
          chk($sformatf("t2_row_r%0d", rows_done), a_row, rows_done);
          strobes++;
          if (strobes == X) gap_rem = K;
          if (rows_done == 1 && strobes == 2 && !stalled) begin
            stall_left = 3; stalled = 1;
          end
        end
      end
      @(posedge clk); #1;
    end
    start = 0;
    if (!fin) chk("t2_timeout", 0, 1);
`ifdef CONV_SEQ_PERF_EN
    chk("t2_stall_cycles", a_stall, exp_stall);
`endif

    // Reset in the middle of row 2, then a clean frame.
    in_valid = 1; out_ready = 1; start = 1;
    @(posedge clk); #1;
    start = 0;
    budget = 0;
    while (!(a_row == 3'd2 && a_lbv === 1'b1) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) chk("t4_reach_row2", 0, 1);
    chk("t4_busy_before", a_busy, 1);
    #2 rstn = 0;
    #1;
    chk_reset("t4_rst");
    @(posedge clk); #1;
    chk("t4_rst_hold_busy", a_busy, 0);
    #2 rstn = 1;
    @(posedge clk); #1;
    run_nostall();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/conv_row_sequencer.md
# conv_row_sequencer

Frame-level sequencer for the convolution input path. It accepts a raster pixel stream under a valid/ready handshake and produces the `valid` and `row_complete` strobes that drive `line_buffer_controller`. It inserts the inter-row drain gap that `line_buffer_controller` needs for right padding, synthesises the bottom zero-padding rows, and reports top/bottom padding masks and window-valid qualification to the MAC array.

## Interface
- `KER_SIZE`, 3: kernel height/width; `KER_SIZE-1 >= PAD` (elaboration assertion).
- `INPUT_X_DIM`, 3: pixels per input row, ≥1.
- `INPUT_Y_DIM`, 3: input rows per frame, ≥1.
- `PAD`, 1: zero-padding rows/cols on each side.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  frame start pulse; sampled only in IDLE.
- `in_valid`  in  1  upstream pixel valid.
- `in_ready`  out  1  pixel accepted when `in_valid && in_ready`.
- `out_ready`  in  1  downstream (line buffer/MAC) can take a column this cycle.
- `lb_valid`  out  1  column strobe to `line_buffer_controller.valid`.
- `lb_row_complete`  out  1  one-cycle row-end pulse to `line_buffer_controller.row_complete`.
- `pad_fill`  out  1  current `lb_valid` column is a synthesised zero (bottom pad row).
- `window_valid`  out  1  `lb_valid` column completes a legal output row window.
- `top_pad_mask`  out  KER_SIZE  kernel rows lying above row 0; bit 0 is the oldest row.
- `bottom_pad_mask`  out  KER_SIZE  kernel rows lying below row `INPUT_Y_DIM-1`.
- `row_idx`  out  $clog2(INPUT_Y_DIM+PAD+1)  current sequencer row.
- `busy`  out  1  high in every state except IDLE.
- `frame_done`  out  1  one-cycle pulse at frame end.

## Operation
- States: IDLE, STREAM, ROW_GAP, PAD_ROW.
- IDLE → STREAM on `start`. `row_idx` and `col_cnt` clear.
- STREAM:
  - `in_ready = out_ready`.
  - `lb_valid = in_valid && out_ready`.
  - Each accepted pixel increments `col_cnt`.
  - On the `INPUT_X_DIM`-th accept: go to ROW_GAP and clear `col_cnt`.
- ROW_GAP:
  - Lasts exactly `KER_SIZE` cycles; `in_ready = 0`, `lb_valid = 0`.
  - `lb_row_complete` is high in the first gap cycle only.
  - `row_idx` increments in the last gap cycle.
  - Exit:
    - If `row_idx` was `INPUT_Y_DIM+PAD-1`: go to IDLE and pulse `frame_done`.
    - Else if the next row is `≥ INPUT_Y_DIM`: go to PAD_ROW.
    - Else: go to STREAM.
- PAD_ROW:
  - `in_ready = 0`, `lb_valid = out_ready`, `pad_fill = lb_valid`.
  - Counts `INPUT_X_DIM` strobes, then goes to ROW_GAP.
  - There are `PAD` pad rows in total; PAD=0 never enters PAD_ROW.
- Window qualification, with `o = row_idx - (KER_SIZE-1-PAD)`:
  - `window_valid = lb_valid && row_idx >= KER_SIZE-1-PAD`.
  - `top_pad_mask[k] = window_valid && (o-PAD+k < 0)`.
  - `bottom_pad_mask[k] = window_valid && (o-PAD+k >= INPUT_Y_DIM)`.
  - Signed compare; operands are one bit wider than `row_idx`.
- `start` outside IDLE is ignored. `in_valid` outside STREAM is ignored and nothing is consumed.
- Reset mid-frame: all state clears asynchronously and returns to IDLE; the partial frame is discarded.

## Timing
- Reset values:
  - State is IDLE.
  - All outputs are 0: `in_ready`, `lb_valid`, `lb_row_complete`, `pad_fill`, `window_valid`, both masks, `row_idx`, `busy`, `frame_done`.
- `start` sampled in cycle N: STREAM and `busy` from cycle N+1.
- `lb_valid`, `in_ready`, `pad_fill`, `window_valid` and the masks are combinational from state/counters plus `in_valid`/`out_ready`, with zero latency.
- `lb_row_complete` and `frame_done` are decoded from registered state and are glitch-free.
- `out_ready` low freezes `col_cnt` in STREAM and PAD_ROW. It does not stall ROW_GAP.
- `frame_done` is high in the first IDLE cycle; `busy` is low in that same cycle.

## Configuration
- `CONV_SEQ_PERF_EN` defined:
  - Adds output `stall_cycles` (32 bits).
  - Counts STREAM cycles with `!(in_valid && out_ready)`.
  - Clears on `start` accept and saturates at all-ones; reset value 0.
- `CONV_SEQ_PERF_EN` undefined: no port and no counter logic.

## Structure
- Package `conv_seq_pkg`:
  - State enum `conv_seq_state_e`.
  - Width helper function for `row_idx`/`col_cnt`.
  - `SEQ_PERF_W = 32`.
- One sub-module: `wrap_counter`, a parameterised modulo counter with enable, sync clear and a terminal-count flag. It is instantiated for column and gap counting.

## Test plan
- KER=3, X=4, Y=4, PAD=1, no stalls, `start` at cycle 0:
  - `lb_valid` in cycles 1-4, 8-11, 15-18, 22-25.
  - Pad row in cycles 29-32 with `pad_fill=1`.
  - `lb_row_complete` at cycles 5, 12, 19, 26, 33.
  - `frame_done` at cycle 36.
- Same config, mask checks:
  - Row 1 window columns give `top_pad_mask=3'b001`.
  - Row 2 gives 0.
  - Pad row 4 gives `bottom_pad_mask=3'b100`.
  - Row 0 gives `window_valid=0`.
- `in_valid` toggling 1/0 with `out_ready` low for 3 cycles mid-row: exactly 4 accepts per row, no lost or duplicated column, gap still `KER_SIZE` cycles.
- PAD=0, KER=3, Y=3:
  - No PAD_ROW.
  - `window_valid` only on row 2.
  - `frame_done` after the third gap.
- `rstn` asserted during row 2 of a frame: all outputs 0 immediately, then a new `start` runs a clean full frame.
- `start` pulsed while busy is ignored. With `CONV_SEQ_PERF_EN`, the counted stall cycles equal the injected idle cycles.
